cache_port_arbiter: RTL and testbench
=====================================

// Module: cache_port_arbiter
// PURPOSE
//  Shares the single cache_ctrl user port (rd_en/wr_en/busy handshake) between two requesters:
//  port 0 = instruction fetch, port 1 = data load/store.
//  Sequences each access through issue/wait/complete, arbitrates round-robin and word-aligns addresses.
//  Flags a stuck controller with a watchdog.
//  Sits between the AHB-lite slave front-ends and cache_ctrl.
// PARAMETERS
//  W_ADDR    32       address width
//  W_DATA    32       data width
//  TIMEOUT   255      max cycles in ISSUE waiting for m_busy or m_hit before abort
//  W_TO      8        watchdog counter width; must satisfy TIMEOUT < 2**W_TO
//  ERR_DATA  32'hDEADBEEF  rdata returned on an aborted read
// PORTS
//  clk        in   1       single clock
//  rst        in   1       synchronous, active-high reset
//  pN_req     in   1       (N=0,1) request; level; fields stable while high until pN_done
//  pN_we      in   1       1=write, 0=read
//  pN_addr    in   W_ADDR  byte address
//  pN_wdata   in   W_DATA  write data
//  pN_mask    in   4       byte-lane mask
//  pN_done    out  1       one-cycle completion pulse
//  pN_rdata   out  W_DATA  read data; valid while pN_done=1, held until that port's next done
//  m_rd_en    out  1       read strobe to cache_ctrl
//  m_wr_en    out  1       write strobe to cache_ctrl
//  m_addr     out  W_ADDR  {addr[W_ADDR-1:2],2'b00}
//  m_wdata    out  W_DATA  latched write data
//  m_mask     out  4       latched mask
//  m_rdata    in   W_DATA  cache_ctrl read data
//  m_busy     in   1       cache_ctrl busy
//  m_hit      in   1       fast-hit qualifier (cache state idle AND c_oe)
//  owner      out  1       port currently granted; valid when busy_o=1
//  busy_o     out  1       1 in any state except IDLE
//  err        out  1       sticky: watchdog abort occurred; cleared only by rst
// BEHAVIOUR
//  Reset values: all outputs 0, state=IDLE, last_owner=1 (so port 0 wins the first tie).
//  FSM states: IDLE, ISSUE, WAIT, DONE.
//  IDLE:
//   - No grant while m_busy=1. This covers reset mid-operation: drain the controller first.
//   - Otherwise pick a requesting port: if both request, take !last_owner; else the single requester.
//   - Latch we/addr/wdata/mask/owner into registers; go to ISSUE.
//  ISSUE:
//   - m_rd_en=!we or m_wr_en=we, held high every ISSUE cycle; watchdog counts up.
//   - Read with m_hit=1: capture m_rdata, go to DONE (hit path; m_busy ignored).
//   - m_busy=1: go to WAIT. If m_busy and m_hit are both high, m_hit wins for reads.
//   - Watchdog reaches TIMEOUT: set err, rdata<=ERR_DATA, go to DONE.
//  WAIT:
//   - Strobes 0.
//   - m_busy=0: capture m_rdata (reads only), go to DONE. No timeout in WAIT.
//  DONE:
//   - Pulse pN_done for owner; last_owner<=owner; clear watchdog; go to IDLE.
//   - The requester's next request is evaluated in IDLE the following cycle.
//  Latency:
//   - Hit read: req seen at t, strobe at t+1, done at t+2.
//   - Miss or write: done 1 cycle after the first m_busy=0 seen in WAIT.
//  Write data is never modified; m_rdata is ignored on writes; pN_rdata is unchanged on writes.
//  Fairness: if both ports hold req continuously, grants strictly alternate 0,1,0,1.
//  A requester dropping req while granted is illegal; the access completes and done still pulses.
//  Exactly one pN_done is high at a time; m_rd_en and m_wr_en are never both high.
// STRUCTURE
//  Shared package cache_arb_pkg:
//   - State encodings S_IDLE/S_ISSUE/S_WAIT/S_DONE (2 bits).
//   - ERR_DATA default.
//   - Port-index constants PORT_I=0, PORT_D=1.
//  Sub-module rr_arb2:
//   - Combinational two-way round-robin pick: inputs req[1:0] and last; outputs gnt_valid and gnt_idx.
//  Top holds the FSM, field latches, watchdog and output muxing.
// TESTING
//  1. Read hit on p0 at addr 0x1003, m_hit=1 in the ISSUE cycle
//     -> m_addr=0x1000, m_rd_en one cycle, p0_done at t+2 with p0_rdata=m_rdata.
//  2. Write on p1 (mask 4'b0110, data 0xA5A5A5A5); m_busy high 1 cycle after strobe, low 5 cycles later
//     -> m_wr_en held until busy, p1_done 1 cycle after busy falls, m_wdata/m_mask match.
//  3. Both ports request continuously for 6 accesses -> grant order 0,1,0,1,0,1; first grant port 0.
//  4. Read on p0 with m_busy and m_hit stuck at 0 -> after 255 ISSUE cycles: err=1, p0_done, p0_rdata=DEADBEEF.
//  5. rst asserted during WAIT while m_busy=1, p1_req high -> outputs 0, no grant until m_busy=0, then p1 served.
//  6. m_busy and m_hit both high on a read in ISSUE -> hit path taken, done at t+2, WAIT never entered.

Source files
------------

// File: rtl/cache_arb_pkg.sv
// Shared types and constants for the cache port arbiter.
// State encodings, error data pattern and port indices.
package cache_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEADBEEF;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick.
// On a tie the port that did not win last time is chosen.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Single requester wins outright; a tie goes to the other port
    always_comb begin
        gnt_valid = |req;
        gnt_idx   = (req == 2'b11) ? ~last : req[1];
    end

endmodule

// File: rtl/cache_port_arbiter.sv
// Shares the cache_ctrl user port between fetch (p0) and load/store (p1).
// Sequences issue/wait/done, word-aligns addresses and runs a watchdog.
module cache_port_arbiter
    import cache_arb_pkg::*;
#(
    parameter int                 W_ADDR   = 32,
    parameter int                 W_DATA   = 32,
    parameter int                 TIMEOUT  = 255,
    parameter int                 W_TO     = 8,
    parameter logic [W_DATA-1:0]  ERR_DATA = W_DATA'(ERR_DATA_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [W_ADDR-1:0] p0_addr,
    input  logic [W_DATA-1:0] p0_wdata,
    input  logic [3:0]        p0_mask,
    output logic              p0_done,
    output logic [W_DATA-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [W_ADDR-1:0] p1_addr,
    input  logic [W_DATA-1:0] p1_wdata,
    input  logic [3:0]        p1_mask,
    output logic              p1_done,
    output logic [W_DATA-1:0] p1_rdata,
    output logic              m_rd_en,
    output logic              m_wr_en,
    output logic [W_ADDR-1:0] m_addr,
    output logic [W_DATA-1:0] m_wdata,
    output logic [3:0]        m_mask,
    input  logic [W_DATA-1:0] m_rdata,
    input  logic              m_busy,
    input  logic              m_hit,
    output logic              owner,
    output logic              busy_o,
    output logic              err
);

    localparam logic [W_TO-1:0] TO_LAST = W_TO'(TIMEOUT - 1);

    state_t              r_state;
    logic                r_last;
    logic                r_owner;
    logic                r_we;
    logic [W_TO-1:0]     r_wd;
    logic                r_err;
    logic                r_p0_done;
    logic                r_p1_done;
    logic [W_DATA-1:0]   r_p0_rdata;
    logic [W_DATA-1:0]   r_p1_rdata;
    logic                r_rd_en;
    logic                r_wr_en;
    logic [W_ADDR-1:0]   r_addr;
    logic [W_DATA-1:0]   r_wdata;
    logic [3:0]          r_mask;

    logic                w_gnt_valid;
    logic                w_gnt_idx;
    logic                w_sel_we;
    logic [W_ADDR-1:0]   w_sel_addr;
    logic [W_DATA-1:0]   w_sel_wdata;
    logic [3:0]          w_sel_mask;
    logic                w_finish;
    logic                w_abort;
    logic [W_DATA-1:0]   w_rd_val;

    rr_arb2 u_arb (
        .req       ({p1_req, p0_req}),
        .last      (r_last),
        .gnt_valid (w_gnt_valid),
        .gnt_idx   (w_gnt_idx)
    );

    // Fields of the port about to be granted
    always_comb begin
        w_sel_we    = w_gnt_idx ? p1_we    : p0_we;
        w_sel_addr  = w_gnt_idx ? p1_addr  : p0_addr;
        w_sel_wdata = w_gnt_idx ? p1_wdata : p0_wdata;
        w_sel_mask  = w_gnt_idx ? p1_mask  : p0_mask;
    end

    // Completion decode: hit read, busy drop in WAIT, or watchdog abort
    always_comb begin
        w_finish = 1'b0;
        w_abort  = 1'b0;
        w_rd_val = m_rdata;
        case (r_state)
            S_ISSUE: begin
                if (!r_we && m_hit) begin
                    w_finish = 1'b1;
                end else if (!m_busy && r_wd == TO_LAST) begin
                    w_finish = 1'b1;
                    w_abort  = 1'b1;
                    w_rd_val = ERR_DATA;
                end
            end
            S_WAIT:  w_finish = !m_busy;
            default: w_finish = 1'b0;
        endcase
    end

    // FSM, field latches, watchdog and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_last     <= PORT_D;
            r_owner    <= PORT_I;
            r_we       <= 1'b0;
            r_wd       <= '0;
            r_err      <= 1'b0;
            r_p0_done  <= 1'b0;
            r_p1_done  <= 1'b0;
            r_p0_rdata <= '0;
            r_p1_rdata <= '0;
            r_rd_en    <= 1'b0;
            r_wr_en    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_mask     <= '0;
        end else begin
            r_p0_done <= 1'b0;
            r_p1_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // Never start while the controller is still draining
                    if (!m_busy && w_gnt_valid) begin
                        r_owner <= w_gnt_idx;
                        r_we    <= w_sel_we;
                        r_addr  <= {w_sel_addr[W_ADDR-1:2], 2'b00};
                        r_wdata <= w_sel_wdata;
                        r_mask  <= w_sel_mask;
                        r_rd_en <= !w_sel_we;
                        r_wr_en <= w_sel_we;
                        r_wd    <= '0;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!w_finish) begin
                        if (m_busy) begin
                            r_rd_en <= 1'b0;
                            r_wr_en <= 1'b0;
                            r_state <= S_WAIT;
                        end else begin
                            r_wd <= r_wd + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_last  <= r_owner;
                    r_wd    <= '0;
                    r_state <= S_IDLE;
                end
                default: ;
            endcase
            if (w_finish) begin
                r_rd_en <= 1'b0;
                r_wr_en <= 1'b0;
                r_state <= S_DONE;
                if (w_abort) r_err <= 1'b1;
                if (r_owner) begin
                    r_p1_done <= 1'b1;
                    if (!r_we) r_p1_rdata <= w_rd_val;
                end else begin
                    r_p0_done <= 1'b1;
                    if (!r_we) r_p0_rdata <= w_rd_val;
                end
            end
        end
    end

    assign p0_done  = r_p0_done;
    assign p1_done  = r_p1_done;
    assign p0_rdata = r_p0_rdata;
    assign p1_rdata = r_p1_rdata;
    assign m_rd_en  = r_rd_en;
    assign m_wr_en  = r_wr_en;
    assign m_addr   = r_addr;
    assign m_wdata  = r_wdata;
    assign m_mask   = r_mask;
    assign owner    = r_owner;
    assign busy_o   = (r_state != S_IDLE);
    assign err      = r_err;

endmodule

// File: tb/tb_cache_port_arbiter.sv
// Self-checking bench for cache_port_arbiter.
// Directed scenarios plus a randomized two-port run against a reference model.
module tb_cache_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req [2];
    logic        we_ [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [3:0]  mask [2];
    logic        p0_done, p1_done;
    logic [31:0] p0_rdata, p1_rdata;
    logic        m_rd_en, m_wr_en;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_mask;
    logic [31:0] m_rdata;
    logic        m_busy, m_hit;
    logic        owner, busy_o, err;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cache_port_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .p0_req   (req[0]),
        .p0_we    (we_[0]),
        .p0_addr  (addr[0]),
        .p0_wdata (wdata[0]),
        .p0_mask  (mask[0]),
        .p0_done  (p0_done),
        .p0_rdata (p0_rdata),
        .p1_req   (req[1]),
        .p1_we    (we_[1]),
        .p1_addr  (addr[1]),
        .p1_wdata (wdata[1]),
        .p1_mask  (mask[1]),
        .p1_done  (p1_done),
        .p1_rdata (p1_rdata),
        .m_rd_en  (m_rd_en),
        .m_wr_en  (m_wr_en),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_mask   (m_mask),
        .m_rdata  (m_rdata),
        .m_busy   (m_busy),
        .m_hit    (m_hit),
        .owner    (owner),
        .busy_o   (busy_o),
        .err      (err)
    );

    task automatic clear_inputs;
        for (int p = 0; p < 2; p++) begin
            req[p] = 1'b0; we_[p] = 1'b0; addr[p] = '0;
            wdata[p] = '0; mask[p] = '0;
        end
        m_rdata = '0; m_busy = 1'b0; m_hit = 1'b0;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({p0_done, p1_done, m_rd_en, m_wr_en, owner, busy_o, err} !== 7'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got %b want 0",
                {p0_done, p1_done, m_rd_en, m_wr_en, owner, busy_o, err});
        end
        checks++;
        if ({m_addr, m_wdata, m_mask, p0_rdata, p1_rdata} !== '0) begin
            failures++;
            $display("FAIL reset_data: addr=%h wdata=%h mask=%h r0=%h r1=%h want 0",
                m_addr, m_wdata, m_mask, p0_rdata, p1_rdata);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || m_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle: busy_o=%b rd=%b want 0 0", busy_o, m_rd_en);
        end
    endtask

    task automatic test_read_hit;
        do_reset();
        m_rdata = 32'h1234_5678;
        req[0] = 1'b1; we_[0] = 1'b0; addr[0] = 32'h1003;
        wdata[0] = 32'h5555_0000; mask[0] = 4'hF;
        @(negedge clk);
        checks++;
        if (m_rd_en !== 1'b1 || m_wr_en !== 1'b0 || m_addr !== 32'h1000 ||
            owner !== 1'b0 || busy_o !== 1'b1) begin
            failures++;
            $display("FAIL hit_issue: rd=%b wr=%b addr=%h own=%b busy=%b want 1 0 00001000 0 1",
                m_rd_en, m_wr_en, m_addr, owner, busy_o);
        end
        m_hit = 1'b1;
        @(negedge clk);
        checks++;
        if (p0_done !== 1'b1 || p1_done !== 1'b0 || p0_rdata !== 32'h1234_5678 ||
            m_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL hit_done: d0=%b d1=%b r0=%h rd=%b want 1 0 12345678 0",
                p0_done, p1_done, p0_rdata, m_rd_en);
        end
        req[0] = 1'b0; m_hit = 1'b0; m_rdata = 32'hFFFF_0000;
        @(negedge clk);
        checks++;
        if (p0_done !== 1'b0 || busy_o !== 1'b0 || p0_rdata !== 32'h1234_5678) begin
            failures++;
            $display("FAIL hit_after: d0=%b busy=%b r0=%h want 0 0 12345678",
                p0_done, busy_o, p0_rdata);
        end
    endtask

    task automatic test_write_miss;
        m_rdata = 32'h0BAD_F00D;
        req[1] = 1'b1; we_[1] = 1'b1; addr[1] = 32'h0000_2006;
        wdata[1] = 32'hA5A5_A5A5; mask[1] = 4'b0110;
        @(negedge clk);
        checks++;
        if (m_wr_en !== 1'b1 || m_rd_en !== 1'b0 || m_wdata !== 32'hA5A5_A5A5 ||
            m_mask !== 4'b0110 || m_addr !== 32'h2004 || owner !== 1'b1) begin
            failures++;
            $display("FAIL wr_issue: wr=%b rd=%b wd=%h mk=%b addr=%h own=%b",
                m_wr_en, m_rd_en, m_wdata, m_mask, m_addr, owner);
        end
        @(negedge clk);
        checks++;
        if (m_wr_en !== 1'b1) begin
            failures++;
            $display("FAIL wr_hold: wr=%b want 1", m_wr_en);
        end
        m_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (m_wr_en !== 1'b0 || p1_done !== 1'b0 || busy_o !== 1'b1) begin
                failures++;
                $display("FAIL wr_wait: cyc=%0d wr=%b d1=%b busy=%b want 0 0 1",
                    i, m_wr_en, p1_done, busy_o);
            end
            if (i == 4) m_busy = 1'b0;
        end
        @(negedge clk);
        checks++;
        if (p1_done !== 1'b1 || p0_done !== 1'b0 || p1_rdata !== 32'h0) begin
            failures++;
            $display("FAIL wr_done: d1=%b d0=%b r1=%h want 1 0 00000000",
                p1_done, p0_done, p1_rdata);
        end
        req[1] = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fairness;
        logic last;
        logic exp_idx;
        int   got;
        do_reset();
        last = 1'b1;
        got = 0;
        req[0] = 1'b1; req[1] = 1'b1; we_[0] = 1'b0; we_[1] = 1'b0;
        addr[0] = 32'h100; addr[1] = 32'h200;
        m_hit = 1'b1; m_rdata = 32'h7777_0001;
        for (int c = 0; c < 100 && got < 6; c++) begin
            @(negedge clk);
            if (p0_done || p1_done) begin
                exp_idx = !last;
                checks++;
                if ((p0_done && p1_done) || p1_done !== exp_idx) begin
                    failures++;
                    $display("FAIL fair_order: n=%0d d0=%b d1=%b want port %0d",
                        got, p0_done, p1_done, exp_idx);
                end
                last = exp_idx;
                got++;
            end
        end
        checks++;
        if (got != 6) begin
            failures++;
            $display("FAIL fair_count: got %0d grants want 6", got);
        end
        req[0] = 1'b0; req[1] = 1'b0; m_hit = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_timeout;
        int n;
        bit seen;
        bit early_err;
        do_reset();
        n = 0; seen = 1'b0; early_err = 1'b0;
        req[0] = 1'b1; we_[0] = 1'b0; addr[0] = 32'h4000;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(negedge clk);
            if (m_rd_en) n++;
            if (m_rd_en && err) early_err = 1'b1;
            if (p0_done) seen = 1'b1;
        end
        checks++;
        if (!seen || n != 255 || early_err) begin
            failures++;
            $display("FAIL to_done: done=%b issue_cycles=%0d early_err=%b want 1 255 0",
                seen, n, early_err);
        end
        checks++;
        if (err !== 1'b1 || p0_rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL to_err: err=%b r0=%h want 1 deadbeef", err, p0_rdata);
        end
        req[0] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL to_sticky: err=%b want 1", err);
        end
    endtask

    task automatic test_reset_mid_wait;
        req[1] = 1'b1; we_[1] = 1'b0; addr[1] = 32'h300B;
        @(negedge clk);
        m_busy = 1'b1;
        @(negedge clk);
        checks++;
        if (m_rd_en !== 1'b0 || busy_o !== 1'b1 || owner !== 1'b1) begin
            failures++;
            $display("FAIL rw_wait: rd=%b busy=%b own=%b want 0 1 1", m_rd_en, busy_o, owner);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({p0_done, p1_done, m_rd_en, m_wr_en, owner, busy_o, err} !== 7'b0 ||
            m_addr !== '0 || p0_rdata !== '0) begin
            failures++;
            $display("FAIL rw_reset: ctl=%b addr=%h r0=%h want 0",
                {p0_done, p1_done, m_rd_en, m_wr_en, owner, busy_o, err}, m_addr, p0_rdata);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (busy_o !== 1'b0 || m_rd_en !== 1'b0 || m_wr_en !== 1'b0) begin
                failures++;
                $display("FAIL rw_drain: cyc=%0d busy=%b rd=%b wr=%b want 0 0 0",
                    i, busy_o, m_rd_en, m_wr_en);
            end
        end
        m_busy = 1'b0;
        @(negedge clk);
        checks++;
        if (m_rd_en !== 1'b1 || owner !== 1'b1 || m_addr !== 32'h3008) begin
            failures++;
            $display("FAIL rw_grant: rd=%b own=%b addr=%h want 1 1 00003008",
                m_rd_en, owner, m_addr);
        end
        m_hit = 1'b1; m_rdata = 32'hCAFE_0005;
        @(negedge clk);
        checks++;
        if (p1_done !== 1'b1 || p1_rdata !== 32'hCAFE_0005) begin
            failures++;
            $display("FAIL rw_done: d1=%b r1=%h want 1 cafe0005", p1_done, p1_rdata);
        end
        req[1] = 1'b0; m_hit = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_busy_and_hit;
        req[0] = 1'b1; we_[0] = 1'b0; addr[0] = 32'h0000_0042;
        m_rdata = 32'h0F0F_1234;
        @(negedge clk);
        m_busy = 1'b1; m_hit = 1'b1;
        @(negedge clk);
        checks++;
        if (p0_done !== 1'b1 || p0_rdata !== 32'h0F0F_1234 || m_rd_en !== 1'b0) begin
            failures++;
            $display("FAIL bh_done: d0=%b r0=%h rd=%b want 1 0f0f1234 0",
                p0_done, p0_rdata, m_rd_en);
        end
        req[0] = 1'b0; m_busy = 1'b0; m_hit = 1'b0;
        @(negedge clk);
        checks++;
        if (busy_o !== 1'b0 || p0_done !== 1'b0) begin
            failures++;
            $display("FAIL bh_idle: busy=%b d0=%b want 0 0", busy_o, p0_done);
        end
    endtask

    task automatic test_random;
        localparam int N = 25;
        int          started [2];
        int          finished [2];
        bit          active [2];
        bit          just [2];
        logic [31:0] exp_rd [2];
        logic [1:0]  req_seen;
        logic        last;
        logic        cur;
        logic        exp_g;
        logic        strobe;
        logic        prev_strobe;
        logic [31:0] cap;
        int          rs;
        int          dly;
        int          blen;
        int          cyc;
        do_reset();
        for (int p = 0; p < 2; p++) begin
            started[p] = 0; finished[p] = 0; active[p] = 1'b0; exp_rd[p] = '0;
        end
        last = 1'b1; cur = 1'b0; prev_strobe = 1'b0; cap = '0;
        rs = 0; dly = 0; blen = 0; cyc = 0;
        while ((finished[0] < N || finished[1] < N) && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            req_seen = {req[1], req[0]};
            strobe = m_rd_en | m_wr_en;
            just[0] = 1'b0; just[1] = 1'b0;
            if (m_rd_en && m_wr_en) begin
                checks++; failures++;
                $display("FAIL rnd_strobes: both rd and wr high");
            end
            if (strobe && !prev_strobe) begin
                exp_g = (req_seen == 2'b11) ? !last : req_seen[1];
                cur = exp_g;
                checks++;
                if (req_seen == 2'b00 || owner !== exp_g ||
                    m_rd_en !== !we_[cur] ||
                    m_addr !== {addr[cur][31:2], 2'b00} ||
                    (we_[cur] && (m_wdata !== wdata[cur] || m_mask !== mask[cur]))) begin
                    failures++;
                    $display("FAIL rnd_grant: req=%b own=%b want %b rd=%b addr=%h want %h",
                        req_seen, owner, exp_g, m_rd_en, m_addr,
                        {addr[cur][31:2], 2'b00});
                end
            end
            prev_strobe = strobe;
            if (rs == 3) begin
                if (!we_[cur]) exp_rd[cur] = cap;
                checks++;
                if ({p1_done, p0_done} !== (cur ? 2'b10 : 2'b01) ||
                    p0_rdata !== exp_rd[0] || p1_rdata !== exp_rd[1]) begin
                    failures++;
                    $display("FAIL rnd_done: d=%b%b want port %0d r0=%h/%h r1=%h/%h",
                        p1_done, p0_done, cur, p0_rdata, exp_rd[0], p1_rdata, exp_rd[1]);
                end
                last = cur;
                active[cur] = 1'b0;
                just[cur] = 1'b1;
                req[cur] = 1'b0;
                finished[cur]++;
                m_hit = 1'b0;
                rs = 0;
            end else if (p0_done || p1_done) begin
                checks++; failures++;
                $display("FAIL rnd_spurious: d=%b%b want 00", p1_done, p0_done);
            end
            if (rs == 2) begin
                if (strobe) begin
                    checks++; failures++;
                    $display("FAIL rnd_wait_strobe: strobe=1 want 0");
                end
                blen--;
                if (blen == 0) begin
                    m_busy = 1'b0;
                    cap = $urandom;
                    m_rdata = cap;
                    rs = 3;
                end
            end
            if (rs == 0 && strobe) begin
                if (!we_[cur] && $urandom_range(0, 2) == 0) begin
                    cap = $urandom;
                    m_rdata = cap;
                    m_hit = 1'b1;
                    rs = 3;
                end else begin
                    dly = $urandom_range(0, 3);
                    rs = 1;
                end
            end else if (rs == 1 && !strobe) begin
                checks++; failures++;
                $display("FAIL rnd_issue_drop: strobe=0 want 1");
            end
            if (rs == 1) begin
                if (dly == 0) begin
                    m_busy = 1'b1;
                    blen = $urandom_range(1, 4);
                    m_rdata = $urandom;
                    rs = 2;
                end else begin
                    dly--;
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (!active[p] && !just[p] && started[p] < N &&
                    $urandom_range(0, 3) == 0) begin
                    active[p] = 1'b1;
                    started[p]++;
                    req[p] = 1'b1;
                    we_[p] = 1'($urandom);
                    addr[p] = $urandom;
                    wdata[p] = $urandom;
                    mask[p] = 4'($urandom);
                end
            end
        end
        checks++;
        if (finished[0] != N || finished[1] != N) begin
            failures++;
            $display("FAIL rnd_complete: p0=%0d p1=%0d want %0d each",
                finished[0], finished[1], N);
        end
        clear_inputs();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_read_hit();
        test_write_miss();
        test_fairness();
        test_timeout();
        test_reset_mid_wait();
        test_busy_and_hit();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
